piso_serializer: RTL and testbench

- Parallel-in/serial-out unloader: captures a WORD_LENGTH word on Start and shifts it out one bit per accepted beat.
- Uses a ready/valid handshake toward the serial consumer.
- Sits downstream of the team's parallel data registers and converts their words to a serial stream.
- Supports a synchronous abort (Rst) alongside the global asynchronous reset.

---
 rtl/piso_serializer.sv | 106 ++++++++++
 tb/tb_piso_serializer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out unloader with a ready/valid handshake toward the serial consumer.
// Build option: define PISO_MSB_FIRST_EN to emit each word MSB-first (default is LSB-first).
module piso_serializer #(
    parameter int WORD_LENGTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   Rst,
    input  logic                   Start,
    input  logic [WORD_LENGTH-1:0] Data_Input,
    input  logic                   Ready_In,
    output logic                   Serial_Out,
    output logic                   Serial_Valid,
    output logic                   Busy,
    output logic                   Done
);

    localparam int COUNT_W = (WORD_LENGTH > 1) ? $clog2(WORD_LENGTH) : 1;
    localparam logic [COUNT_W-1:0] LAST_COUNT = COUNT_W'(WORD_LENGTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t                 state_reg;
    logic [WORD_LENGTH-1:0] shift_reg;
    logic [COUNT_W-1:0]     count_reg;
    logic                   valid_reg;
    logic                   busy_reg;
    logic                   done_reg;
    logic [WORD_LENGTH-1:0] shift_next;

    // Zero fill keeps Serial_Out low once the word has drained.
`ifdef PISO_MSB_FIRST_EN
    assign shift_next = {shift_reg[WORD_LENGTH-2:0], 1'b0};
    assign Serial_Out = shift_reg[WORD_LENGTH-1];
`else
    assign shift_next = {1'b0, shift_reg[WORD_LENGTH-1:1]};
    assign Serial_Out = shift_reg[0];
`endif

    assign Serial_Valid = valid_reg;
    assign Busy         = busy_reg;
    assign Done         = done_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            shift_reg <= '0;
            count_reg <= '0;
            valid_reg <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else if (Rst) begin
            state_reg <= IDLE;
            shift_reg <= '0;
            count_reg <= '0;
            valid_reg <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg <= 1'b0;
                    if (Start) begin
                        state_reg <= SHIFT;
                        shift_reg <= Data_Input;
                        count_reg <= '0;
                        valid_reg <= 1'b1;
                        busy_reg  <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (Ready_In) begin
                        shift_reg <= shift_next;
                        if (count_reg == LAST_COUNT) begin
                            // Counter parks at zero instead of wrapping past the last bit.
                            state_reg <= DONE;
                            count_reg <= '0;
                            valid_reg <= 1'b0;
                            done_reg  <= 1'b1;
                        end else begin
                            count_reg <= count_reg + COUNT_W'(1);
                        end
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                    shift_reg <= '0;
                    count_reg <= '0;
                    valid_reg <= 1'b0;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer: directed table, corner sequences, and random
// traffic against a queue-of-bits reference model.
module tb_piso_serializer;

    localparam int WL = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          Rst;
    logic          Start;
    logic [WL-1:0] Data_Input;
    logic          Ready_In;
    logic          Serial_Out;
    logic          Serial_Valid;
    logic          Busy;
    logic          Done;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: bits still to be delivered, plus the pending Done cycle.
    bit q[$];
    bit m_done;

    typedef struct {
        logic          start;
        logic [WL-1:0] data;
        logic          ready;
        logic          rst;
        logic          valid;
        logic          busy;
        logic          done;
        logic          sout;
    } vec_t;

    vec_t tbl[10];

    always #5 clk = ~clk;

    piso_serializer #(.WORD_LENGTH(WL)) dut (
        .clk         (clk),
        .reset       (reset),
        .Rst         (Rst),
        .Start       (Start),
        .Data_Input  (Data_Input),
        .Ready_In    (Ready_In),
        .Serial_Out  (Serial_Out),
        .Serial_Valid(Serial_Valid),
        .Busy        (Busy),
        .Done        (Done)
    );

    task automatic check(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_word(input string name, input logic [WL-1:0] act, input logic [WL-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end else begin
            $display("word %s: %h", name, act);
        end
    endtask

    task automatic model_load(input logic [WL-1:0] d);
        for (int i = 0; i < WL; i++) begin
`ifdef PISO_MSB_FIRST_EN
            q.push_back(d[WL-1-i]);
`else
            q.push_back(d[i]);
`endif
        end
    endtask

    task automatic model_clear();
        q.delete();
        m_done = 1'b0;
    endtask

    // Advances the model by one clock edge using the inputs present at that edge.
    task automatic model_edge();
        if (Rst) begin
            model_clear();
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (q.size() > 0) begin
            if (Ready_In) begin
                void'(q.pop_front());
                if (q.size() == 0) m_done = 1'b1;
            end
        end else if (Start) begin
            model_load(Data_Input);
        end
    endtask

    task automatic check_model(input string tag);
        logic ev, eb, es;
        ev = (q.size() > 0);
        eb = ev || m_done;
        es = ev ? q[0] : 1'b0;
        check({tag, ".valid"}, Serial_Valid, ev);
        check({tag, ".busy"}, Busy, eb);
        check({tag, ".done"}, Done, m_done);
        check({tag, ".sout"}, Serial_Out, es);
    endtask

    task automatic step(input logic s, input logic [WL-1:0] d, input logic rdy, input logic r,
                        input string tag);
        Start      = s;
        Data_Input = d;
        Ready_In   = rdy;
        Rst        = r;
        @(posedge clk);
        model_edge();
        #1;
        check_model(tag);
        $display("%s: start=%b data=%h rdy=%b rst=%b -> sout=%b valid=%b busy=%b done=%b",
                 tag, s, d, rdy, r, Serial_Out, Serial_Valid, Busy, Done);
    endtask

    // Collects one bit per accepted beat (Ready_In held high) into word order.
    task automatic drain_word(input logic hold_start, output logic [WL-1:0] w);
        w = '0;
        for (int i = 0; i < WL; i++) begin
`ifdef PISO_MSB_FIRST_EN
            w[WL-1-i] = Serial_Out;
`else
            w[i] = Serial_Out;
`endif
            step(hold_start, 8'hFF, 1'b1, 1'b0, "drain");
        end
    endtask

    initial begin
        logic [WL-1:0] w;
        int            n;

        // A5 is a bit palindrome, so the same table holds for either bit order.
        tbl[0] = '{1'b1, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[1] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[7] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[8] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[9] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        reset = 1'b1; Rst = 1'b0; Start = 1'b0; Data_Input = '0; Ready_In = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check_model("reset");
        @(negedge clk);
        reset = 1'b0;

        // Directed table: full A5 transfer with Ready_In high.
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].start, tbl[i].data, tbl[i].ready, tbl[i].rst, $sformatf("tbl%0d", i));
            check($sformatf("tbl%0d.valid", i), Serial_Valid, tbl[i].valid);
            check($sformatf("tbl%0d.busy", i), Busy, tbl[i].busy);
            check($sformatf("tbl%0d.done", i), Done, tbl[i].done);
            check($sformatf("tbl%0d.sout", i), Serial_Out, tbl[i].sout);
        end

        // Stall for two cycles on the 4th bit: Done arrives two cycles late.
        step(1'b1, 8'hA5, 1'b1, 1'b0, "stall_load");
        repeat (3) step(1'b0, 8'h00, 1'b1, 1'b0, "stall_pre");
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 8'h00, 1'b0, 1'b0, "stall_hold");
            check("stall.sout", Serial_Out, 1'b0);
            check("stall.valid", Serial_Valid, 1'b1);
        end
        n = 5;
        while (!Done && n < 40) begin
            step(1'b0, 8'h00, 1'b1, 1'b0, "stall_post");
            n++;
        end
        check("stall.done_seen", Done, 1'b1);
        check("stall.latency_ok", (n == WL + 2), 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b0, "stall_idle");

        // Start held during a 0F transfer and during DONE is ignored.
        step(1'b1, 8'h0F, 1'b1, 1'b0, "ign_load");
        drain_word(1'b1, w);
        check_word("ignored_start_0F", w, 8'h0F);
        check("ign.done", Done, 1'b1);
        step(1'b1, 8'hFF, 1'b1, 1'b0, "ign_done_start");
        check("ign.busy_after", Busy, 1'b0);

        // Rst mid-word discards the rest; a following 81 transfer is clean.
        step(1'b1, 8'h3C, 1'b1, 1'b0, "rst_load");
        repeat (3) step(1'b0, 8'h00, 1'b1, 1'b0, "rst_pre");
        step(1'b0, 8'h00, 1'b1, 1'b1, "rst_abort");
        check("rst.busy", Busy, 1'b0);
        check("rst.valid", Serial_Valid, 1'b0);
        repeat (3) begin
            step(1'b0, 8'h00, 1'b1, 1'b0, "rst_after");
            check("rst.no_done", Done, 1'b0);
        end
        step(1'b1, 8'h55, 1'b1, 1'b1, "rst_and_start");
        check("rst_start.busy", Busy, 1'b0);
        step(1'b1, 8'h81, 1'b1, 1'b0, "rst_next_load");
        drain_word(1'b0, w);
        check_word("after_rst_81", w, 8'h81);
        step(1'b0, 8'h00, 1'b1, 1'b0, "rst_idle");

        // Asynchronous reset between edges mid-transfer.
        step(1'b1, 8'hFF, 1'b1, 1'b0, "async_load");
        step(1'b0, 8'h00, 1'b1, 1'b0, "async_shift");
        #2;
        reset = 1'b1;
        #1;
        check("async.valid", Serial_Valid, 1'b0);
        check("async.busy", Busy, 1'b0);
        check("async.done", Done, 1'b0);
        check("async.sout", Serial_Out, 1'b0);
        model_clear();
        @(negedge clk);
        reset = 1'b0;
        step(1'b0, 8'h00, 1'b1, 1'b0, "async_idle");

        // Randomized traffic against the reference model.
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 2) == 0), WL'($urandom), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 49) == 0), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
